delta_liafn_neuron: RTL and testbench
=====================================

# delta_liafn_neuron

Single delta-input leaky integrate-and-fire neuron (LIAFN) in the TinyTapeout user-project wrapper (top module name `delta_liafn`). It takes an 8-bit input current on `ui_in`. In delta mode it integrates the absolute sample-to-sample change of that input; in direct mode it integrates the input value itself. A configurable shift-based leak and a threshold apply, followed by a fixed refractory period. Spike and membrane potential are exposed on `uo_out`; the bidirectional bus is used as input-only configuration.

## Interface
Parameters:
- none; all widths fixed as listed.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous reset, active-high; the name is kept per the codebase, but the polarity is 1 = reset.
- `ena`  in  1  enable; 0 freezes all state.
- `ui_in`  in  8  input current sample `I`, unsigned.
- `uio_in`  in  8  configuration:
  - `[7:4]` = threshold nibble; `TH = {uio_in[7:4], 4'hF}`, range 15..255.
  - `[3]` = mode; 1 = direct, 0 = delta.
  - `[2:0]` = leak shift `S`.
- `uo_out`  out  8  `[7]` = spike; `[6:0]` = `V[7:1]`.
- `uio_out`  out  8  constant 0.
- `uio_oe`  out  8  constant 0; all uio pins are inputs.

## Operation
State registers:
- `V[7:0]` membrane potential.
- `prev[7:0]` last sampled input.
- `refr[1:0]` refractory counter.
- `spike` output flag.

On each rising edge with `rst_n=0` and `ena=1`:
- Drive `d`:
  - Direct mode: `d = ui_in`.
  - Delta mode: `d = |ui_in - prev|`, computed unsigned with no wrap.
- Update `prev <= ui_in` every enabled cycle, in both modes and during refractory.
- Leak: `leak = (S==0) ? 0 : (V >> S)`.
- If `refr != 0`: `V <= 0`, `refr <= refr-1`, `spike <= 0`. Input is ignored except for the `prev` update.
- Else:
  - `sum = V - leak + d`, computed at 10 bits; it is never negative.
  - Saturate `sum` to 255.
  - If `sum >= TH`: `spike <= 1`, `V <= 0`, `refr <= 2`.
  - Otherwise: `spike <= 0`, `V <= sum`.

With `ena=0`:
- `V`, `prev` and `refr` hold.
- `spike <= 0`.

Outputs:
- `uo_out = {spike, V[7:1]}`, purely registered; no combinational path from inputs to outputs.
- Configuration is sampled live every cycle; changing it mid-integration takes effect on the next edge.

## Timing
- Reset (`rst_n=1` at an edge): `V=0`, `prev=0`, `refr=0`, `spike=0`. Hence `uo_out=0x00`, `uio_out=0x00`, `uio_oe=0x00`.
- Reset dominates `ena` and any refractory or integration in progress.
- Latency: inputs sampled at edge k are reflected in `uo_out` immediately after edge k, one-cycle registered.
- Spike width is exactly one cycle. The spike edge also zeroes `V`.
- Refractory: the two enabled edges after the spike force `V=0`. Integration resumes on the third enabled edge after the spike edge.
- Minimum inter-spike spacing is therefore 3 enabled cycles.
- Saturation: `sum > 255` clamps to 255. `TH` max is 255, so a saturated sum always fires.
- Delta mode after reset: `prev=0`, so the first sample's `d` equals `ui_in`.

## Test plan
- Reset: hold `rst_n=1` for 2 cycles with random `ui_in`/`uio_in` -> `uo_out=0x00`, `uio_out=0x00`, `uio_oe=0x00`.
- Direct integrate/fire: `uio_in=0xF8` (TH=255, direct, S=0), `ui_in=0x40`, `ena=1`.
  - `uo_out` after edges 1..4 = `0x20`, `0x40`, `0x60`, `0x80`.
  - Edges 5 and 6 -> `0x00` (refractory).
  - Edge 7 -> `0x20`.
- Delta mode: `uio_in=0x30` (TH=63, delta, S=0), `ui_in` held at `0x55` from reset.
  - Edge 1 -> `uo_out=0x80`.
  - Afterwards `uo_out` stays `0x00` indefinitely (`d=0`).
  - Stepping `ui_in` to `0x10` -> `d=0x45` -> spike on that edge.
- Leak: `uio_in=0xF9` (TH=255, direct, S=1), `ui_in=0x10`.
  - `V` = 16, 24, 28, 30, 31, 32, 32, ...
  - `uo_out` settles at `0x10`; never spikes.
- Enable freeze: in the direct test after `V=0x80`, drop `ena` for 5 cycles -> `uo_out` holds `0x40` and no spike occurs. Re-enable -> `V=0xC0` next edge.
- Reset mid-refractory: assert `rst_n=1` on the edge right after a spike, then release -> integration restarts from `V=0` on the first enabled edge after release, with no refractory cycles.

Source files
------------

// File: rtl/delta_liafn_neuron.sv
// ---------------------------------------------------------------------------
// delta_liafn_neuron
//
// Single leaky integrate-and-fire neuron driven by an 8-bit input current.
// In delta mode it integrates the absolute sample-to-sample change of the
// input. In direct mode it integrates the raw sample. A shift-based leak and
// a programmable threshold apply, followed by a fixed two-cycle refractory
// period.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst_n    in   1  synchronous reset, ACTIVE-HIGH (1 = reset) despite the name
//   ena      in   1  enable; 0 freezes V/prev/refr and clears spike
//   ui_in    in   8  input current sample, unsigned
//   uio_in   in   8  config: [7:4] threshold nibble (TH = {nib, 4'hF}),
//                            [3] mode (1 = direct, 0 = delta),
//                            [2:0] leak shift S (0 = no leak)
//   uo_out   out  8  {spike, V[7:1]}, purely registered
//   uio_out  out  8  constant 0
//   uio_oe   out  8  constant 0 (all uio pins are inputs)
//
// There is no valid/ready handshake on this block: a sample is consumed on
// every rising edge where ena=1, and the result appears on uo_out right after
// that same edge. ena=0 edges consume nothing.
// ---------------------------------------------------------------------------
module delta_liafn_neuron (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // State
    logic [7:0] v;       // membrane potential
    logic [7:0] prev;    // last sampled input (for delta mode)
    logic [1:0] refr;    // refractory cycles remaining
    logic       spike;

    // Live configuration
    logic [7:0] th;
    logic       mode_direct;
    logic [2:0] shift;

    // Datapath
    logic [7:0] d;
    logic [7:0] leak;
    logic [9:0] sum;
    logic [7:0] sum_sat;

    always_comb begin
        th          = {uio_in[7:4], 4'hF};
        mode_direct = uio_in[3];
        shift       = uio_in[2:0];

        // Absolute difference computed by ordered subtraction so it never wraps.
        if (mode_direct) begin
            d = ui_in;
        end else if (ui_in >= prev) begin
            d = ui_in - prev;
        end else begin
            d = prev - ui_in;
        end

        // S=0 means "no leak", not "leak everything".
        if (shift == 3'd0) begin
            leak = 8'd0;
        end else begin
            leak = v >> shift;
        end

        // leak <= v always, so the 10-bit sum never goes negative.
        sum = {2'b00, v} - {2'b00, leak} + {2'b00, d};

        if (sum > 10'd255) begin
            sum_sat = 8'hFF;
        end else begin
            sum_sat = sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            v     <= 8'd0;
            prev  <= 8'd0;
            refr  <= 2'd0;
            spike <= 1'b0;
        end else if (ena) begin
            // prev tracks the input even while refractory, so delta mode
            // does not see a stale jump when integration resumes.
            prev <= ui_in;
            if (refr != 2'd0) begin
                v     <= 8'd0;
                refr  <= refr - 2'd1;
                spike <= 1'b0;
            end else if (sum_sat >= th) begin
                v     <= 8'd0;
                refr  <= 2'd2;
                spike <= 1'b1;
            end else begin
                v     <= sum_sat;
                spike <= 1'b0;
            end
        end else begin
            // Spike is a one-cycle pulse; a frozen neuron must not repeat it.
            spike <= 1'b0;
        end
    end

    assign uo_out  = {spike, v[7:1]};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_delta_liafn_neuron.sv
// ---------------------------------------------------------------------------
// tb_delta_liafn_neuron
//
// Directed, table-driven bench for delta_liafn_neuron. Each table row is one
// rising edge: the inputs to apply before the edge and the uo_out expected
// right after it. A hand-written sequence covers reset landing on the edge
// right after a spike.
// ---------------------------------------------------------------------------
module tb_delta_liafn_neuron;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    delta_liafn_neuron dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] ui;
        logic [7:0] uio;
        logic [7:0] exp_uo;
        string      name;
    } vec_t;

    vec_t vec_q[$];

    function automatic void add(input logic rst, input logic en,
                                input logic [7:0] ui, input logic [7:0] uio,
                                input logic [7:0] exp_uo, input string name);
        vec_t v;
        v.rst    = rst;
        v.en     = en;
        v.ui     = ui;
        v.uio    = uio;
        v.exp_uo = exp_uo;
        v.name   = name;
        vec_q.push_back(v);
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Drive one row, take one edge, sample #1 after it.
    task automatic step(input logic rst, input logic en, input logic [7:0] ui,
                        input logic [7:0] uio, input logic [7:0] exp_uo, input string name);
        rst_n  = rst;
        ena    = en;
        ui_in  = ui;
        uio_in = uio;
        @(posedge clk);
        #1;
        check8({name, " uo_out"}, uo_out, exp_uo);
        check8({name, " uio_out"}, uio_out, 8'h00);
        check8({name, " uio_oe"}, uio_oe, 8'h00);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset with random inputs
        add(1, 1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h00, "reset0");
        add(1, 0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h00, "reset1");

        // Direct mode, TH=255, S=0, I=0x40: 64,128,192,sat->spike
        add(0, 1, 8'h40, 8'hF8, 8'h20, "dir e1");
        add(0, 1, 8'h40, 8'hF8, 8'h40, "dir e2");
        add(0, 1, 8'h40, 8'hF8, 8'h60, "dir e3");
        add(0, 1, 8'h40, 8'hF8, 8'h80, "dir e4 spike");
        add(0, 1, 8'h40, 8'hF8, 8'h00, "dir e5 refr");
        add(0, 1, 8'h40, 8'hF8, 8'h00, "dir e6 refr");
        add(0, 1, 8'h40, 8'hF8, 8'h20, "dir e7 resume");
        add(0, 1, 8'h40, 8'hF8, 8'h40, "dir V=0x80");
        // Enable freeze for 5 cycles
        for (int i = 0; i < 5; i++) add(0, 0, 8'h40, 8'hF8, 8'h40, "freeze");
        add(0, 1, 8'h40, 8'hF8, 8'h60, "unfreeze V=0xC0");
        add(0, 1, 8'h40, 8'hF8, 8'h80, "unfreeze spike");
        add(0, 1, 8'h40, 8'hF8, 8'h00, "refr a");
        add(0, 1, 8'h40, 8'hF8, 8'h00, "refr b");

        // Delta mode, TH=63, ui held at 0x55 from reset
        add(1, 1, 8'h55, 8'h30, 8'h00, "delta reset");
        add(0, 1, 8'h55, 8'h30, 8'h80, "delta first spike");
        for (int i = 0; i < 6; i++) add(0, 1, 8'h55, 8'h30, 8'h00, "delta steady");
        add(0, 1, 8'h10, 8'h30, 8'h80, "delta step 0x45");
        add(0, 1, 8'h10, 8'h30, 8'h00, "delta refr a");
        add(0, 1, 8'h10, 8'h30, 8'h00, "delta refr b");
        add(0, 1, 8'h10, 8'h30, 8'h00, "delta flat");
        add(0, 1, 8'h30, 8'h30, 8'h10, "delta up 32");
        add(0, 1, 8'h20, 8'h30, 8'h18, "delta down 16");
        add(0, 1, 8'h30, 8'h30, 8'h80, "delta up 16 fire");

        // Leak S=1, I=0x10: V = 16,24,28,30,31,32,32,32
        add(1, 1, 8'h10, 8'hF9, 8'h00, "leak reset");
        add(0, 1, 8'h10, 8'hF9, 8'h08, "leak V16");
        add(0, 1, 8'h10, 8'hF9, 8'h0C, "leak V24");
        add(0, 1, 8'h10, 8'hF9, 8'h0E, "leak V28");
        add(0, 1, 8'h10, 8'hF9, 8'h0F, "leak V30");
        add(0, 1, 8'h10, 8'hF9, 8'h0F, "leak V31");
        add(0, 1, 8'h10, 8'hF9, 8'h10, "leak V32");
        add(0, 1, 8'h10, 8'hF9, 8'h10, "leak V32 b");
        add(0, 1, 8'h10, 8'hF9, 8'h10, "leak V32 c");
        // Live config change: S=0 from V=32 -> 48
        add(0, 1, 8'h10, 8'hF8, 8'h18, "cfg change S=0");

        // Threshold boundary TH=31 direct S=0: 30 holds, 31 fires
        add(1, 1, 8'h00, 8'h18, 8'h00, "th reset");
        add(0, 1, 8'h1E, 8'h18, 8'h0F, "th below V30");
        add(0, 1, 8'h01, 8'h18, 8'h80, "th equal fires");

        foreach (vec_q[i])
            step(vec_q[i].rst, vec_q[i].en, vec_q[i].ui, vec_q[i].uio,
                 vec_q[i].exp_uo, vec_q[i].name);

        // Reset on the edge right after a spike: no refractory afterwards,
        // and reset wins even with ena low.
        step(1, 1, 8'h00, 8'hF8, 8'h00, "mid reset pre");
        step(0, 1, 8'hFF, 8'hF8, 8'h80, "mid spike");
        step(1, 0, 8'hFF, 8'hF8, 8'h00, "mid reset");
        step(0, 1, 8'h40, 8'hF8, 8'h20, "mid resume V64");
        step(0, 1, 8'h40, 8'hF8, 8'h40, "mid resume V128");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
